// File: rtl/tt_pin_responder.sv
// Device side of the host pin link: 4-phase req/ack byte handshake serving
// reads and writes to a 16 x 8-bit register file, with sticky error and a
// wrapping transaction counter reported on uio_out.
module tt_pin_responder #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    typedef enum logic [1:0] {
        IDLE,
        CMD_ACK,
        WAIT_DATA,
        DATA_ACK
    } state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   req_s;

    logic       ack_q, ack_d;
    logic       latch_cmd;
    logic       do_write;
    logic       inc_cnt;

    logic       cmd_we_q;
    logic       cmd_valid_q;
    logic [3:0] cmd_addr_q;

    logic [7:0] regs_q [16];
    logic [7:0] rd_data_q;
    logic       rd_valid_q;
    logic       err_q;
    logic [3:0] txn_cnt_q;

    logic       in_valid;
    logic       in_read;
    logic       unused_uio;

    assign req_s      = sync_q[SYNC_STAGES-1];
    assign in_valid   = (ui_in[6:4] == 3'b000);
    assign in_read    = in_valid && !ui_in[7];
    assign unused_uio = ^uio_in[7:1];

    // req is asynchronous to clk, so it only enters the FSM through this chain
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], uio_in[0]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
        end
    end

    // Handshake sequencing; ena low parks the FSM in IDLE with ack dropped
    always_comb begin
        state_d   = state_q;
        ack_d     = ack_q;
        latch_cmd = 1'b0;
        do_write  = 1'b0;
        inc_cnt   = 1'b0;
        if (!ena) begin
            state_d = IDLE;
            ack_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_s) begin
                        latch_cmd = 1'b1;
                        ack_d     = 1'b1;
                        state_d   = CMD_ACK;
                    end
                end
                CMD_ACK: begin
                    if (!req_s) begin
                        ack_d = 1'b0;
                        if (cmd_valid_q && cmd_we_q) begin
                            state_d = WAIT_DATA;
                        end else begin
                            state_d = IDLE;
                            inc_cnt = cmd_valid_q;
                        end
                    end
                end
                WAIT_DATA: begin
                    if (req_s) begin
                        do_write = 1'b1;
                        ack_d    = 1'b1;
                        state_d  = DATA_ACK;
                    end
                end
                DATA_ACK: begin
                    if (!req_s) begin
                        ack_d   = 1'b0;
                        inc_cnt = 1'b1;
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    ack_d   = 1'b0;
                end
            endcase
        end
    end

    // Command capture, read data, sticky error and counter
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_we_q    <= 1'b0;
            cmd_valid_q <= 1'b0;
            cmd_addr_q  <= 4'h0;
            rd_data_q   <= 8'h00;
            rd_valid_q  <= 1'b0;
            err_q       <= 1'b0;
            txn_cnt_q   <= 4'h0;
        end else begin
            if (latch_cmd) begin
                cmd_we_q    <= ui_in[7];
                cmd_valid_q <= in_valid;
                cmd_addr_q  <= ui_in[3:0];
                rd_valid_q  <= in_read;
                if (in_read) begin
                    rd_data_q <= regs_q[ui_in[3:0]];
                end
                if (!in_valid) begin
                    err_q <= 1'b1;
                end
            end
            if (inc_cnt) begin
                txn_cnt_q <= txn_cnt_q + 4'h1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                regs_q[i] <= 8'h00;
            end
        end else if (do_write) begin
            regs_q[cmd_addr_q] <= ui_in;
        end
    end

    assign uo_out  = rd_data_q;
    assign uio_out = {txn_cnt_q, err_q, rd_valid_q, ack_q, 1'b0};
    assign uio_oe  = 8'hFE;

endmodule

// File: tb/tb_tt_pin_responder.sv
// Self-checking bench for tt_pin_responder: directed and random host
// transactions compared against a transaction-level register-file model.
module tb_tt_pin_responder;

    localparam int SYNC_STAGES = 2;
    localparam int MAX_WAIT    = 20;

    logic       clk;
    logic       rst;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int vectors;
    int miscompares;

    logic [7:0] model_regs [16];
    logic [7:0] model_uo;
    logic       model_rd;
    logic       model_err;
    int         model_cnt;

    tt_pin_responder #(.SYNC_STAGES(SYNC_STAGES)) dut (
        .clk    (clk),
        .rst    (rst),
        .ena    (ena),
        .ui_in  (ui_in),
        .uio_in (uio_in),
        .uo_out (uo_out),
        .uio_out(uio_out),
        .uio_oe (uio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < 16; i++) model_regs[i] = 8'h00;
        model_uo  = 8'h00;
        model_rd  = 1'b0;
        model_err = 1'b0;
        model_cnt = 0;
    endtask

    task automatic checkStatus(input string tag);
        checkOutput({tag, " uo_out"}, {24'h0, uo_out}, {24'h0, model_uo});
        checkOutput({tag, " status"}, {28'h0, uio_out[3:0]},
                    {28'h0, model_err, model_rd, uio_out[1], 1'b0});
        checkOutput({tag, " txn_cnt"}, {28'h0, uio_out[7:4]}, model_cnt % 16);
    endtask

    // Every handshake edge must appear exactly SYNC_STAGES+1 ticks after req changes
    task automatic waitAck(input logic level, input string tag);
        int n;
        n = 0;
        while (uio_out[1] !== level && n < MAX_WAIT) begin
            tick();
            n++;
        end
        checkOutput({tag, " ack latency"}, n, SYNC_STAGES + 1);
    endtask

    task automatic applyStimulus(input logic [7:0] cmd, input logic [7:0] data, input string tag);
        logic valid;
        valid = (cmd[6:4] == 3'b000);
        ui_in     = cmd;
        uio_in[0] = 1'b1;
        waitAck(1'b1, {tag, " cmd rise"});
        if (valid && !cmd[7]) begin
            model_uo = model_regs[cmd[3:0]];
            model_rd = 1'b1;
        end else begin
            model_rd = 1'b0;
        end
        if (!valid) model_err = 1'b1;
        checkStatus({tag, " cmd"});
        uio_in[0] = 1'b0;
        waitAck(1'b0, {tag, " cmd fall"});
        if (valid && !cmd[7]) model_cnt++;
        checkStatus({tag, " cmd done"});
        if (valid && cmd[7]) begin
            ui_in     = data;
            uio_in[0] = 1'b1;
            waitAck(1'b1, {tag, " data rise"});
            model_regs[cmd[3:0]] = data;
            uio_in[0] = 1'b0;
            waitAck(1'b0, {tag, " data fall"});
            model_cnt++;
            checkStatus({tag, " data done"});
        end
    endtask

    initial begin
        logic [7:0] cmd;
        logic [7:0] data;
        vectors     = 0;
        miscompares = 0;
        rst    = 1'b1;
        ena    = 1'b1;
        ui_in  = 8'h00;
        uio_in = 8'h00;
        modelReset();

        tick();
        tick();
        checkOutput("reset uo_out", {24'h0, uo_out}, 32'h00);
        checkOutput("reset uio_out", {24'h0, uio_out}, 32'h00);
        checkOutput("reset uio_oe", {24'h0, uio_oe}, 32'hFE);
        rst = 1'b0;
        tick();

        for (int a = 0; a < 16; a++) applyStimulus(8'(a), 8'h00, "reset read");

        applyStimulus(8'h83, 8'hA5, "write a5");
        applyStimulus(8'h03, 8'h00, "read back");
        checkOutput("read back value", {24'h0, uo_out}, 32'hA5);

        applyStimulus(8'h13, 8'h00, "invalid 13");
        checkOutput("invalid err", {31'h0, uio_out[3]}, 32'h1);
        applyStimulus(8'h03, 8'h00, "read after err");
        checkOutput("err sticky", {31'h0, uio_out[3]}, 32'h1);

        for (int i = 0; i < 60; i++) begin
            cmd  = 8'($urandom);
            data = 8'($urandom);
            if ($urandom_range(0, 7) != 0) cmd[6:4] = 3'b000;
            applyStimulus(cmd, data, "random");
        end

        // Abandon a write sitting in WAIT_DATA
        applyStimulus(8'h02, 8'h00, "pre abort");
        ui_in     = 8'h82;
        uio_in[0] = 1'b1;
        waitAck(1'b1, "abort cmd rise");
        model_rd  = 1'b0;
        uio_in[0] = 1'b0;
        waitAck(1'b0, "abort cmd fall");
        ena = 1'b0;
        tick();
        tick();
        checkOutput("abort ack", {31'h0, uio_out[1]}, 32'h0);
        ena = 1'b1;
        tick();
        applyStimulus(8'h02, 8'h00, "abort readback");
        checkOutput("abort reg2", {24'h0, uo_out}, {24'h0, model_regs[2]});

        // ena drop forces ack low while the command is still acked
        ui_in     = 8'h05;
        uio_in[0] = 1'b1;
        waitAck(1'b1, "ena cmd rise");
        model_uo = model_regs[5];
        model_rd = 1'b1;
        ena = 1'b0;
        tick();
        checkOutput("ena forces ack", {31'h0, uio_out[1]}, 32'h0);
        uio_in[0] = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        ena = 1'b1;
        tick();
        checkStatus("ena drop");

        // Reset while in DATA_ACK
        ui_in     = 8'h87;
        uio_in[0] = 1'b1;
        waitAck(1'b1, "rst cmd rise");
        uio_in[0] = 1'b0;
        waitAck(1'b0, "rst cmd fall");
        ui_in     = 8'h3C;
        uio_in[0] = 1'b1;
        waitAck(1'b1, "rst data rise");
        rst       = 1'b1;
        uio_in[0] = 1'b0;
        tick();
        checkOutput("mid rst uo_out", {24'h0, uo_out}, 32'h00);
        checkOutput("mid rst uio_out", {24'h0, uio_out}, 32'h00);
        checkOutput("mid rst uio_oe", {24'h0, uio_oe}, 32'hFE);
        rst = 1'b0;
        modelReset();
        for (int i = 0; i < 4; i++) tick();
        applyStimulus(8'h07, 8'h00, "post rst read");
        checkOutput("post rst reg7", {24'h0, uo_out}, 32'h00);

        for (int i = 0; i < 17; i++) applyStimulus(8'($urandom_range(0, 15)), 8'h00, "wrap read");
        checkOutput("wrap txn_cnt", {28'h0, uio_out[7:4]}, 32'h2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
